// File: rtl/gt_link_reset_pkg.sv
// Shared constants for the GT link reset controller: state encodings and counter widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gt_link_reset_pkg;

    localparam int STATE_W = 3;
    localparam int RETRY_W = 8;

    localparam logic [STATE_W-1:0] ST_RESET_ALL = 3'd0;
    localparam logic [STATE_W-1:0] ST_WAIT_TX   = 3'd1;
    localparam logic [STATE_W-1:0] ST_WAIT_RX   = 3'd2;
    localparam logic [STATE_W-1:0] ST_RX_RESET  = 3'd3;
    localparam logic [STATE_W-1:0] ST_STABLE    = 3'd4;
    localparam logic [STATE_W-1:0] ST_LINK_UP   = 3'd5;
    localparam logic [STATE_W-1:0] ST_FAULT     = 3'd6;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gt_link_reset_ctrl_timer.sv
// Loadable down-counter that parks at zero; expired flags the last cycle of a loaded interval.
// Latency: load takes effect on the next clock; expired is combinational from the count.
// Backpressure: none; free-running on init_clk.
module gt_rst_timer #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         init_clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    // Reload on strobe, otherwise count down and hold at zero.
    always_ff @(posedge init_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/gt_link_reset_ctrl.sv
// Bring-up / recovery FSM for one GT channel: sequences full and RX-datapath resets, retries, faults.
// Latency: outputs are registered from the next-state decode, so they change with the state register.
// Backpressure: none; soft_reset is a level request that pins the FSM in RESET_ALL while high.
module gt_link_reset_ctrl
    import gt_link_reset_pkg::*;
#(
    parameter int RESET_PULSE_CYCLES = 16,
    parameter int TX_TIMEOUT_CYCLES  = 1048576,
    parameter int RX_TIMEOUT_CYCLES  = 1048576,
    parameter int STABLE_CYCLES      = 1024,
    parameter int MAX_RETRIES        = 7
) (
    input  logic               init_clk,
    input  logic               rst_n,
    input  logic               tx_good_init_synced,
    input  logic               rx_good_init_synced,
    input  logic               soft_reset,
    output logic               gt_reset_all,
    output logic               gt_reset_rx_datapath,
    output logic               link_up,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [STATE_W-1:0] state_dbg
);

    localparam int MAX_CYC = max_of(max_of(RESET_PULSE_CYCLES, TX_TIMEOUT_CYCLES),
                                    max_of(RX_TIMEOUT_CYCLES, STABLE_CYCLES));
    localparam int TW = $clog2(MAX_CYC) + 1;

    // Timer load values are interval-1 so expiry lands on the last cycle of the interval.
    localparam logic [TW-1:0] PULSE_LD  = TW'(RESET_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TX_LD     = TW'(TX_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] RX_LD     = TW'(RX_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] STABLE_LD = TW'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [STATE_W-1:0] retry_tgt;
    logic               do_retry;
    logic [RETRY_W-1:0] retry_nxt;
    logic               tmr_load;
    logic               tmr_exp;
    logic [TW-1:0]      tmr_val;

    gt_rst_timer #(
        .W       (TW),
        .RST_VAL (PULSE_LD)
    ) u_timer (
        .init_clk (init_clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_exp)
    );

    // Next-state decode: soft_reset, then tx loss, then rx loss, then timer expiry, then advance.
    always_comb begin
        state_nxt = state;
        do_retry  = 1'b0;
        retry_tgt = ST_RESET_ALL;
        if (soft_reset) begin
            state_nxt = ST_RESET_ALL;
        end else begin
            case (state)
                ST_RESET_ALL: begin
                    if (tmr_exp) state_nxt = ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (tmr_exp) begin
                        do_retry  = 1'b1;
                        retry_tgt = ST_RESET_ALL;
                    end else if (tx_good_init_synced) begin
                        state_nxt = ST_WAIT_RX;
                    end
                end
                ST_WAIT_RX: begin
                    if (!tx_good_init_synced) begin
                        do_retry  = 1'b1;
                        retry_tgt = ST_RESET_ALL;
                    end else if (tmr_exp) begin
                        do_retry  = 1'b1;
                        retry_tgt = ST_RX_RESET;
                    end else if (rx_good_init_synced) begin
                        state_nxt = ST_STABLE;
                    end
                end
                ST_RX_RESET: begin
                    if (tmr_exp) state_nxt = ST_WAIT_RX;
                end
                ST_STABLE: begin
                    if (!tx_good_init_synced) begin
                        do_retry  = 1'b1;
                        retry_tgt = ST_RESET_ALL;
                    end else if (!rx_good_init_synced) begin
                        // rx flicker restarts the stability window without costing a retry
                        state_nxt = ST_WAIT_RX;
                    end else if (tmr_exp) begin
                        state_nxt = ST_LINK_UP;
                    end
                end
                ST_LINK_UP: begin
                    // Losses from a live link are recoveries, not retries.
                    if (!tx_good_init_synced) begin
                        state_nxt = ST_RESET_ALL;
                    end else if (!rx_good_init_synced) begin
                        state_nxt = ST_RX_RESET;
                    end
                end
                ST_FAULT: begin
                    state_nxt = ST_FAULT;
                end
                default: begin
                    state_nxt = ST_RESET_ALL;
                end
            endcase
            if (do_retry) begin
                state_nxt = (retry_cnt == RETRY_MAX) ? ST_FAULT : retry_tgt;
            end
        end
    end

    // Retry bookkeeping: cleared on restart or link-up entry, otherwise saturating increment.
    always_comb begin
        retry_nxt = retry_cnt;
        if (soft_reset || (state_nxt == ST_LINK_UP && state != ST_LINK_UP)) begin
            retry_nxt = '0;
        end else if (do_retry && retry_cnt != RETRY_MAX && retry_cnt != '1) begin
            retry_nxt = retry_cnt + 1'b1;
        end
    end

    // Timer reloads on every state entry, and continuously while soft_reset is held.
    always_comb begin
        tmr_load = soft_reset || (state_nxt != state);
        case (state_nxt)
            ST_RESET_ALL: tmr_val = PULSE_LD;
            ST_RX_RESET:  tmr_val = PULSE_LD;
            ST_WAIT_TX:   tmr_val = TX_LD;
            ST_WAIT_RX:   tmr_val = RX_LD;
            ST_STABLE:    tmr_val = STABLE_LD;
            default:      tmr_val = '0;
        endcase
    end

    // State and Moore outputs, registered together so they switch in the same cycle.
    always_ff @(posedge init_clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= ST_RESET_ALL;
            gt_reset_all         <= 1'b1;
            gt_reset_rx_datapath <= 1'b0;
            link_up              <= 1'b0;
            fault                <= 1'b0;
            retry_cnt            <= '0;
        end else begin
            state                <= state_nxt;
            gt_reset_all         <= (state_nxt == ST_RESET_ALL);
            gt_reset_rx_datapath <= (state_nxt == ST_RX_RESET);
            link_up              <= (state_nxt == ST_LINK_UP);
            fault                <= (state_nxt == ST_FAULT);
            retry_cnt            <= retry_nxt;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_gt_link_reset_ctrl.sv
// Bench for gt_link_reset_ctrl with short timing parameters.
// Latency: checks sampled 1ns after the rising edge.
// Backpressure: n/a.
module tb_gt_link_reset_ctrl;

    localparam logic [2:0] RA  = 3'd0;
    localparam logic [2:0] WTX = 3'd1;
    localparam logic [2:0] WRX = 3'd2;
    localparam logic [2:0] RXR = 3'd3;
    localparam logic [2:0] STB = 3'd4;
    localparam logic [2:0] LNK = 3'd5;
    localparam logic [2:0] FLT = 3'd6;

    logic       init_clk = 1'b0;
    logic       rst_n;
    logic       tx_good;
    logic       rx_good;
    logic       soft_reset;
    logic       gt_reset_all;
    logic       gt_reset_rx_datapath;
    logic       link_up;
    logic       fault;
    logic [7:0] retry_cnt;
    logic [2:0] state_dbg;

    always #5 init_clk = ~init_clk;

    gt_link_reset_ctrl #(
        .RESET_PULSE_CYCLES (4),
        .TX_TIMEOUT_CYCLES  (32),
        .RX_TIMEOUT_CYCLES  (32),
        .STABLE_CYCLES      (8),
        .MAX_RETRIES        (2)
    ) dut (
        .init_clk             (init_clk),
        .rst_n                (rst_n),
        .tx_good_init_synced  (tx_good),
        .rx_good_init_synced  (rx_good),
        .soft_reset           (soft_reset),
        .gt_reset_all         (gt_reset_all),
        .gt_reset_rx_datapath (gt_reset_rx_datapath),
        .link_up              (link_up),
        .fault                (fault),
        .retry_cnt            (retry_cnt),
        .state_dbg            (state_dbg)
    );

    // {gt_reset_all, gt_reset_rx_datapath, link_up, fault, retry_cnt[7:0], state[2:0]}
    typedef struct {
        logic        sr;
        logic        tx;
        logic        rx;
        int          n;
        logic [14:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [14:0] sb[$];
    int          total = 0;
    int          bad   = 0;

    function automatic logic [14:0] ex(input logic all, input logic rxdp, input logic lk,
                                       input logic flt, input logic [7:0] rc, input logic [2:0] st);
        return {all, rxdp, lk, flt, rc, st};
    endfunction

    task automatic add(input logic s, input logic t, input logic r, input int n, input logic [14:0] e);
        vec_t v;
        v.sr  = s;
        v.tx  = t;
        v.rx  = r;
        v.n   = n;
        v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic compare(input string nm);
        logic [14:0] got;
        logic [14:0] want;
        got  = {gt_reset_all, gt_reset_rx_datapath, link_up, fault, retry_cnt, state_dbg};
        want = sb.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got all=%b rxdp=%b link=%b fault=%b retry=%0d state=%0d ; want all=%b rxdp=%b link=%b fault=%b retry=%0d state=%0d",
                     nm, got[14], got[13], got[12], got[11], got[10:3], got[2:0],
                     want[14], want[13], want[12], want[11], want[10:3], want[2:0]);
        end
    endtask

    // Drive inputs, queue the expectation, advance n edges, then check.
    task automatic run(input string nm, input logic s, input logic t, input logic r,
                       input int n, input logic [14:0] e);
        soft_reset = s;
        tx_good    = t;
        rx_good    = r;
        sb.push_back(e);
        repeat (n) @(posedge init_clk);
        #1;
        compare(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000ns");
        $fatal(1);
    end

    initial begin
        // Bring-up: tx_good at cycle 10, rx_good at cycle 15.
        add(0, 0, 0,  3, ex(1, 0, 0, 0, 0, RA));
        add(0, 0, 0,  1, ex(0, 0, 0, 0, 0, WTX));
        add(0, 0, 0,  6, ex(0, 0, 0, 0, 0, WTX));
        add(0, 1, 0,  1, ex(0, 0, 0, 0, 0, WRX));
        add(0, 1, 0,  4, ex(0, 0, 0, 0, 0, WRX));
        add(0, 1, 1,  1, ex(0, 0, 0, 0, 0, STB));
        add(0, 1, 1,  7, ex(0, 0, 0, 0, 0, STB));
        add(0, 1, 1,  1, ex(0, 0, 1, 0, 0, LNK));
        // tx_good held low: RESET_ALL pulses every 36 cycles, FAULT on the third timeout.
        add(0, 0, 0,  1, ex(1, 0, 0, 0, 0, RA));
        add(0, 0, 0,  4, ex(0, 0, 0, 0, 0, WTX));
        add(0, 0, 0, 31, ex(0, 0, 0, 0, 0, WTX));
        add(0, 0, 0,  1, ex(1, 0, 0, 0, 1, RA));
        add(0, 0, 0, 36, ex(1, 0, 0, 0, 2, RA));
        add(0, 0, 0, 35, ex(0, 0, 0, 0, 2, WTX));
        add(0, 0, 0,  1, ex(0, 0, 0, 1, 2, FLT));
        add(0, 0, 0, 20, ex(0, 0, 0, 1, 2, FLT));
        // soft_reset clears fault and retries; pulse counts from its fall.
        add(1, 0, 0,  1, ex(1, 0, 0, 0, 0, RA));
        add(1, 0, 0,  5, ex(1, 0, 0, 0, 0, RA));
        add(0, 1, 0,  3, ex(1, 0, 0, 0, 0, RA));
        add(0, 1, 0,  1, ex(0, 0, 0, 0, 0, WTX));
        // tx good, rx never good: RX datapath retries, then FAULT.
        add(0, 1, 0,  1, ex(0, 0, 0, 0, 0, WRX));
        add(0, 1, 0, 31, ex(0, 0, 0, 0, 0, WRX));
        add(0, 1, 0,  1, ex(0, 1, 0, 0, 1, RXR));
        add(0, 1, 0,  3, ex(0, 1, 0, 0, 1, RXR));
        add(0, 1, 0,  1, ex(0, 0, 0, 0, 1, WRX));
        add(0, 1, 0, 32, ex(0, 1, 0, 0, 2, RXR));
        add(0, 1, 0,  4, ex(0, 0, 0, 0, 2, WRX));
        add(0, 1, 0, 32, ex(0, 0, 0, 1, 2, FLT));
        // Recover to LINK_UP.
        add(1, 1, 1,  1, ex(1, 0, 0, 0, 0, RA));
        add(0, 1, 1,  4, ex(0, 0, 0, 0, 0, WTX));
        add(0, 1, 1,  1, ex(0, 0, 0, 0, 0, WRX));
        add(0, 1, 1,  1, ex(0, 0, 0, 0, 0, STB));
        add(0, 1, 1,  7, ex(0, 0, 0, 0, 0, STB));
        add(0, 1, 1,  1, ex(0, 0, 1, 0, 0, LNK));
        // One-cycle rx loss from LINK_UP: RX_RESET pulse, no retry, link returns.
        add(0, 1, 0,  1, ex(0, 1, 0, 0, 0, RXR));
        add(0, 1, 1,  3, ex(0, 1, 0, 0, 0, RXR));
        add(0, 1, 1,  1, ex(0, 0, 0, 0, 0, WRX));
        add(0, 1, 1,  1, ex(0, 0, 0, 0, 0, STB));
        add(0, 1, 1,  7, ex(0, 0, 0, 0, 0, STB));
        add(0, 1, 1,  1, ex(0, 0, 1, 0, 0, LNK));

        rst_n      = 1'b0;
        soft_reset = 1'b0;
        tx_good    = 1'b0;
        rx_good    = 1'b0;
        repeat (3) @(posedge init_clk);
        #1;
        sb.push_back(ex(1, 0, 0, 0, 0, RA));
        compare("reset_values");
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run($sformatf("vec%0d", i), tbl[i].sr, tbl[i].tx, tbl[i].rx, tbl[i].n, tbl[i].exp);
        end

        // rx glitch at stable count 6: window restarts via WAIT_RX, no retry.
        run("gl_drop",     0, 1, 0, 1, ex(0, 1, 0, 0, 0, RXR));
        run("gl_rxr",      0, 1, 1, 3, ex(0, 1, 0, 0, 0, RXR));
        run("gl_wrx",      0, 1, 1, 1, ex(0, 0, 0, 0, 0, WRX));
        run("gl_stb",      0, 1, 1, 1, ex(0, 0, 0, 0, 0, STB));
        run("gl_cnt6",     0, 1, 1, 6, ex(0, 0, 0, 0, 0, STB));
        run("gl_glitch",   0, 1, 0, 1, ex(0, 0, 0, 0, 0, WRX));
        run("gl_restable", 0, 1, 1, 1, ex(0, 0, 0, 0, 0, STB));
        run("gl_nolink",   0, 1, 1, 7, ex(0, 0, 0, 0, 0, STB));
        run("gl_link",     0, 1, 1, 1, ex(0, 0, 1, 0, 0, LNK));

        // Both goods drop together: tx loss wins, full reset.
        run("both_drop",   0, 0, 0, 1, ex(1, 0, 0, 0, 0, RA));
        run("bd_wtx",      0, 1, 1, 4, ex(0, 0, 0, 0, 0, WTX));
        run("bd_wrx",      0, 1, 1, 1, ex(0, 0, 0, 0, 0, WRX));
        run("bd_stb",      0, 1, 1, 1, ex(0, 0, 0, 0, 0, STB));
        run("bd_link",     0, 1, 1, 8, ex(0, 0, 1, 0, 0, LNK));

        // Async reset in the middle of an RX_RESET pulse.
        run("ar_rxdrop",   0, 1, 0, 1, ex(0, 1, 0, 0, 0, RXR));
        run("ar_midpulse", 0, 1, 1, 2, ex(0, 1, 0, 0, 0, RXR));
        rst_n = 1'b0;
        #2;
        sb.push_back(ex(1, 0, 0, 0, 0, RA));
        compare("arst_immediate");
        repeat (2) @(posedge init_clk);
        #1;
        sb.push_back(ex(1, 0, 0, 0, 0, RA));
        compare("arst_hold");
        rst_n = 1'b1;
        run("arst_pulse",  0, 1, 1, 3, ex(1, 0, 0, 0, 0, RA));
        run("arst_wtx",    0, 1, 1, 1, ex(0, 0, 0, 0, 0, WTX));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
